// File: rtl/aes_result_collector_if.sv
// aes_result_collector_if: job type plus the issuer/pipeline/host bundle of the AES result collector
package aes_rc_pkg;
  typedef enum logic [1:0] {INVALID = 2'd0, ENCRYPT = 2'd1, DECRYPT = 2'd2} job_t;
endpackage

interface aes_result_collector_if #(parameter int TAG_W = 4);
  import aes_rc_pkg::*;
  logic issue_valid;
  logic [127:0] in_data;
  job_t in_type;
  logic [TAG_W-1:0] in_tag;
  logic can_issue;
  logic out_valid;
  logic out_ready;
  logic [127:0] out_data;
  job_t out_type;
  logic [TAG_W-1:0] out_tag;
  logic overflow;
  logic spurious;
  modport slave (
    input issue_valid, in_data, in_type, in_tag, out_ready,
    output can_issue, out_valid, out_data, out_type, out_tag, overflow, spurious
  );
  modport master (
    output issue_valid, in_data, in_type, in_tag, out_ready,
    input can_issue, out_valid, out_data, out_type, out_tag, overflow, spurious
  );
endinterface

// File: rtl/aes_result_collector.sv
// aes_result_collector: buffers AES pipeline results in a FWFT FIFO and issues credits to the job issuer
module aes_result_collector
  import aes_rc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PIPE_LAT = 10,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  aes_result_collector_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(PIPE_LAT + 1);
  localparam int EW = 128 + 2 + TAG_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [FW-1:0] FLUSH0 = FW'(PIPE_LAT);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CW-1:0] count, count_nx, inflight, inflight_nx;
  logic [FW-1:0] flush;
  logic arrival, pop, push, drop;
  logic [EW-1:0] in_ent, head_nx;
  logic [127:0] out_data_q;
  logic [1:0] out_type_q;
  logic [TAG_W-1:0] out_tag_q;
  logic overflow_q, spurious_q;

  always_comb begin
    arrival = bus.in_type != INVALID && flush == '0;
    pop = bus.out_valid && bus.out_ready;
    push = arrival && (count != FULL || pop);
    drop = arrival && count == FULL && !pop;
    rd_ptr_nx = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_nx = count + CW'(push) - CW'(pop);
    in_ent = {bus.in_data, bus.in_type, bus.in_tag};
    // the slot becoming head may be the one written this same edge
    head_nx = push && rd_ptr_nx == wr_ptr ? in_ent : mem[rd_ptr_nx];
    inflight_nx = bus.issue_valid && !arrival ? (inflight == FULL ? inflight : inflight + CW'(1))
                : arrival && !bus.issue_valid && inflight != '0 ? inflight - CW'(1)
                : inflight;
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_ent;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      inflight <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      flush <= FLUSH0;
      overflow_q <= 1'b0;
      spurious_q <= 1'b0;
      out_data_q <= '0;
      out_type_q <= INVALID;
      out_tag_q <= '0;
    end else begin
      flush <= flush == '0 ? flush : flush - FW'(1);
      count <= count_nx;
      inflight <= inflight_nx;
      rd_ptr <= rd_ptr_nx;
      wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
      overflow_q <= overflow_q | drop;
      spurious_q <= spurious_q | (arrival && inflight == '0);
      out_type_q <= count_nx != '0 ? head_nx[TAG_W +: 2] : INVALID;
      if (count_nx != '0) begin
        out_data_q <= head_nx[EW-1 -: 128];
        out_tag_q <= head_nx[TAG_W-1:0];
      end
    end
  end

  assign bus.can_issue = flush == '0 && ({1'b0, count} + {1'b0, inflight}) < {1'b0, FULL};
  assign bus.out_valid = count != '0;
  assign bus.out_data = out_data_q;
  assign bus.out_type = job_t'(out_type_q);
  assign bus.out_tag = out_tag_q;
  assign bus.overflow = overflow_q;
  assign bus.spurious = spurious_q;
endmodule
